// File: rtl/inst_fetch.sv
// Purpose: instruction fetch unit; holds the PC, reads the combinational
//          instruction memory and queues {pc, inst} pairs for decode.
// Latency: a word fetched in cycle N appears at out_* in cycle N+1.
// Backpressure: the 2-entry queue absorbs stalls; when it is full and
//               decode is not popping, ce drops and pc holds.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   ce, addr, inst          instruction-memory read port (inst same-cycle)
//   redirect_valid/_pc      taken branch/jump; flushes queue, restarts fetch
//   out_valid/_ready        valid/ready handshake towards decode
//   out_inst, out_pc        queue head contents (zero when empty)
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ce,
  output logic [31:0] addr,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  logic [31:0]  pc;
  fetch_entry_t queue [2];
  logic [1:0]   count;
  logic         head;
  logic         tail;

  logic         pop;
  logic         push;
  logic [31:0]  redirect_target;
  fetch_entry_t head_entry;

  // Low two bits of the target are discarded so fetch stays word-aligned.
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  assign out_valid  = (count != 2'd0);
  assign head_entry = queue[head];
  assign out_pc     = out_valid ? head_entry.pc   : 32'h0;
  assign out_inst   = out_valid ? head_entry.inst : 32'h0;

  assign pop  = out_valid & out_ready;

  // A pop in the same cycle frees a slot, so a full queue can still fetch.
  // rst_n gates ce so the memory sees no fetch while reset is held.
  assign push = rst_n & ~redirect_valid & ((count != 2'd2) | pop);
  assign ce   = push;
  assign addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      count          <= 2'd0;
      head           <= 1'b0;
      tail           <= 1'b0;
      queue[0]       <= '0;
      queue[1]       <= '0;
    end else if (redirect_valid) begin
      // Flush wins over everything, including a pop decode took this cycle.
      pc    <= redirect_target;
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        queue[tail] <= '{pc: pc, inst: inst};
        tail        <= ~tail;
        pc          <= pc + 32'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int n_cmp;
  int n_err;

  // Reference model: queue of fetched PCs and the next PC to fetch.
  logic [31:0] mq [$];
  logic [31:0] mpc;

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ce             (ce),
    .addr           (addr),
    .inst           (inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word k holds value k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign inst = mem_word(addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        pop;
    logic        exp_ce;
    logic [31:0] hp;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    pop    = (mq.size() != 0) && rdy;
    exp_ce = !rv && ((mq.size() < 2) || pop);
    hp     = (mq.size() != 0) ? mq[0] : 32'h0;
    chk("ce", {31'b0, ce}, {31'b0, exp_ce});
    chk("addr", addr, mpc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("out_pc", out_pc, hp);
    chk("out_inst", out_inst, (mq.size() != 0) ? mem_word(hp) : 32'h0);
    if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (exp_ce) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();

    // Outputs while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ce", {31'b0, ce}, 32'h0);
    chk("rst_addr", addr, RPC);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    // Backpressure from a fresh reset: pc must stall at 0x8.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
    chk("bp_addr", addr, 32'h0000_0008);
    chk("bp_ce", {31'b0, ce}, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect while streaming, unaligned target.
    step(1'b1, 32'h0000_0103, 1'b1);
    chk("rd_addr", addr, 32'h0000_0100);
    chk("rd_out_valid", {31'b0, out_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("rd_out_pc", out_pc, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect with a full queue and a pop in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0200, 1'b1);
    chk("rdfull_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rdfull_addr", addr, 32'h0000_0200);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects, then PC wrap at the top of memory.
    step(1'b1, 32'h0000_0400, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_pc2", out_pc, 32'h0000_0000);

    // Randomised traffic: stalls, redirects (some back-to-back).
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset between edges with a full queue.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    chk("pre_arst_valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_ce", {31'b0, ce}, 32'h0);
    chk("arst_addr", addr, RPC);
    chk("arst_out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
